fir_mac_alu: RTL and testbench

- Parametrised, pipelined signed arithmetic unit for the FIR core.
- Successor to the fixed 16-bit add/multiply ALU:
  - generic operand and accumulator widths;
  - adds multiply-accumulate and accumulator-clear modes;
  - valid handshake with fixed 2-cycle latency;
  - sticky overflow detection.
- Sits between the sample/coefficient fetch logic and the FIR output register. One MAC per tap per cycle.

---
 rtl/fir_mac_alu.sv | 103 ++++++++++
 tb/tb_fir_mac_alu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_alu.sv
// Two-stage pipelined signed add / multiply / multiply-accumulate unit for the FIR core.
// Build option: define FIR_MAC_ALU_SAT_EN to saturate the accumulator on MAC overflow (default wraps).
module fir_mac_alu #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [1:0]               select,
  output logic signed [ACC_W-1:0]  result,
  output logic                     out_valid,
  output logic                     ovf
);

  if (ACC_W < 2 * DATA_W) begin : g_width_check
    $error("fir_mac_alu: ACC_W must be at least 2*DATA_W");
  end

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_MAC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  op_e                       mode1;
  logic                      valid1;
  logic signed [2*DATA_W-1:0] prod1;
  logic signed [DATA_W:0]     sum1;
  logic signed [ACC_W-1:0]    acc;

  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum_ext;
  logic signed [ACC_W-1:0]    mac_sum;
  logic signed [ACC_W-1:0]    mac_val;
  logic                       mac_ovf;

  // Stage 1: operands are only captured on valid cycles; bubbles just clear valid1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1 <= 1'b0;
      mode1  <= OP_ADD;
      prod1  <= '0;
      sum1   <= '0;
    end else begin
      valid1 <= in_valid;
      if (in_valid) begin
        mode1 <= op_e'(select);
        prod1 <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
        sum1  <= (DATA_W+1)'(a) + (DATA_W+1)'(b);
      end
    end
  end

  always_comb begin
    prod_ext = ACC_W'(prod1);
    sum_ext  = ACC_W'(sum1);
    mac_sum  = acc + prod_ext;
    // Signed overflow: same-sign operands producing a sum of the other sign.
    mac_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (mac_sum[ACC_W-1] != acc[ACC_W-1]);
    mac_val  = mac_sum;
`ifdef FIR_MAC_ALU_SAT_EN
    if (mac_ovf) begin
      mac_val = prod_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  // Stage 2: the accumulator is only read and written here, so back-to-back MACs need no forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= valid1;
      if (valid1) begin
        case (mode1)
          OP_ADD: result <= sum_ext;
          OP_MUL: result <= prod_ext;
          OP_MAC: begin
            result <= mac_val;
            acc    <= mac_val;
            if (mac_ovf) ovf <= 1'b1;
          end
          OP_CLR: begin
            result <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
          end
          default: result <= result;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_alu.sv
// Self-checking bench for fir_mac_alu: directed scenarios against literal values and a
// randomized run against an arithmetic reference model of the accumulator.
module tb_fir_mac_alu;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic [1:0]               select;
  logic signed [ACC_W-1:0]  result;
  logic                     out_valid;
  logic                     ovf;

  fir_mac_alu #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .select(select), .result(result), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; longint res; bit ovf; } exp_t;
  typedef struct { bit v; logic [1:0] s; int a; int b; } op_t;

  exp_t   pend[$];
  longint m_acc, m_res;
  bit     m_ovf;
  int     n_checks = 0;
  int     n_fail   = 0;

  // Expected visible state once an operation has left the pipeline.
  function automatic exp_t model(bit v, logic [1:0] s, longint av, longint bv);
    longint t;
    if (v) begin
      case (s)
        2'd0: m_res = av + bv;
        2'd1: m_res = av * bv;
        2'd2: begin
          t = m_acc + av * bv;
          if (t > MAXV || t < MINV) begin
            m_ovf = 1'b1;
`ifdef FIR_MAC_ALU_SAT_EN
            t = (t > MAXV) ? MAXV : MINV;
`else
            t = (t > MAXV) ? t - (64'sd1 <<< ACC_W) : t + (64'sd1 <<< ACC_W);
`endif
          end
          m_acc = t;
          m_res = t;
        end
        default: begin
          m_acc = 0;
          m_res = 0;
          m_ovf = 1'b0;
        end
      endcase
    end
    return '{v, m_res, m_ovf};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_res = 0; m_ovf = 1'b0;
    pend.delete();
    pend.push_back('{1'b0, 0, 1'b0});
  endtask

  // Drives one cycle; returns the model's expectation for what is visible after this edge.
  task automatic cycle(input op_t op, output exp_t e);
    in_valid = op.v;
    select   = op.s;
    a        = DATA_W'(op.a);
    b        = DATA_W'(op.b);
    pend.push_back(model(op.v, op.s, longint'(op.a), longint'(op.b)));
    @(posedge clk); #1;
    e = pend.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; select = 2'd0; a = '0; b = '0;
    model_reset();
    #3;
    n_checks++;
    if (result !== '0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: result=%0d out_valid=%b ovf=%b, required 0/0/0", result, out_valid, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_add_mul();
    op_t  ops[5] = '{'{1, 2'd0, 100, -30}, '{1, 2'd1, -3, 7}, '{1, 2'd1, -32768, -32768},
                     '{0, 2'd0, 0, 0}, '{0, 2'd0, 0, 0}};
    exp_t lit[5] = '{'{0, 0, 0}, '{1, 70, 0}, '{1, -21, 0}, '{1, 1073741824, 0}, '{0, 1073741824, 0}};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      cycle(ops[i], e);
      n_checks++;
      if (out_valid !== lit[i].v || result !== ACC_W'(lit[i].res) || ovf !== lit[i].ovf) begin
        n_fail++;
        $display("FAIL add_mul[%0d]: got v=%b res=%0d ovf=%b, required v=%b res=%0d ovf=%b",
                 i, out_valid, result, ovf, lit[i].v, lit[i].res, lit[i].ovf);
      end
    end
  endtask

  task automatic test_mac_chain();
    op_t  ops[8] = '{'{1, 2'd3, 0, 0}, '{1, 2'd2, 2, 3}, '{1, 2'd2, 4, 5}, '{1, 2'd2, -1, 6},
                     '{1, 2'd0, 1, 1}, '{1, 2'd2, 1, 0}, '{0, 2'd0, 0, 0}, '{0, 2'd0, 0, 0}};
    exp_t lit[8] = '{'{0, 0, 0}, '{1, 0, 0}, '{1, 6, 0}, '{1, 26, 0}, '{1, 20, 0},
                     '{1, 2, 0}, '{1, 20, 0}, '{0, 20, 0}};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      cycle(ops[i], e);
      if (i == 0) continue;
      n_checks++;
      if (out_valid !== lit[i].v || result !== ACC_W'(lit[i].res) || ovf !== lit[i].ovf) begin
        n_fail++;
        $display("FAIL mac_chain[%0d]: got v=%b res=%0d ovf=%b, required v=%b res=%0d ovf=%b",
                 i, out_valid, result, ovf, lit[i].v, lit[i].res, lit[i].ovf);
      end
    end
  endtask

  task automatic test_bubble();
    op_t  ops[6] = '{'{1, 2'd3, 0, 0}, '{1, 2'd2, 2, 3}, '{0, 2'd2, 9, 9}, '{1, 2'd2, 2, 3},
                     '{0, 2'd0, 0, 0}, '{0, 2'd0, 0, 0}};
    exp_t lit[6] = '{'{0, 0, 0}, '{1, 0, 0}, '{1, 6, 0}, '{0, 6, 0}, '{1, 12, 0}, '{0, 12, 0}};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      cycle(ops[i], e);
      if (i == 0) continue;
      n_checks++;
      if (out_valid !== lit[i].v || result !== ACC_W'(lit[i].res) || ovf !== lit[i].ovf) begin
        n_fail++;
        $display("FAIL bubble[%0d]: got v=%b res=%0d ovf=%b, required v=%b res=%0d ovf=%b",
                 i, out_valid, result, ovf, lit[i].v, lit[i].res, lit[i].ovf);
      end
    end
  endtask

  task automatic test_overflow();
`ifdef FIR_MAC_ALU_SAT_EN
    longint third = 2147483647;
`else
    longint third = -1073938429;
`endif
    op_t  ops[7] = '{'{1, 2'd3, 0, 0}, '{1, 2'd2, 32767, 32767}, '{1, 2'd2, 32767, 32767},
                     '{1, 2'd2, 32767, 32767}, '{1, 2'd3, 0, 0}, '{0, 2'd0, 0, 0}, '{0, 2'd0, 0, 0}};
    exp_t lit[7];
    exp_t e;
    lit = '{'{0, 0, 0}, '{1, 0, 0}, '{1, 1073676289, 0}, '{1, 2147352578, 0},
            '{1, third, 1}, '{1, 0, 0}, '{0, 0, 0}};
    for (int i = 0; i < 7; i++) begin
      cycle(ops[i], e);
      if (i == 0) continue;
      n_checks++;
      if (out_valid !== lit[i].v || result !== ACC_W'(lit[i].res) || ovf !== lit[i].ovf) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got v=%b res=%0d ovf=%b, required v=%b res=%0d ovf=%b",
                 i, out_valid, result, ovf, lit[i].v, lit[i].res, lit[i].ovf);
      end
    end
  endtask

  task automatic test_clear_precedence();
    op_t  ops[5] = '{'{1, 2'd2, 1000, 1000}, '{1, 2'd3, 0, 0}, '{1, 2'd2, 5, 5},
                     '{0, 2'd0, 0, 0}, '{0, 2'd0, 0, 0}};
    exp_t lit[5] = '{'{0, 0, 0}, '{1, 1000000, 0}, '{1, 0, 0}, '{1, 25, 0}, '{0, 25, 0}};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      cycle(ops[i], e);
      if (i < 2) continue;
      n_checks++;
      if (out_valid !== lit[i].v || result !== ACC_W'(lit[i].res) || ovf !== lit[i].ovf) begin
        n_fail++;
        $display("FAIL clear_prec[%0d]: got v=%b res=%0d ovf=%b, required v=%b res=%0d ovf=%b",
                 i, out_valid, result, ovf, lit[i].v, lit[i].res, lit[i].ovf);
      end
    end
  endtask

  task automatic test_random();
    op_t  op;
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      op.v = ($urandom_range(0, 4) != 0);
      op.s = 2'($urandom_range(0, 3));
      if (op.s == 2'd3 && $urandom_range(0, 3) != 0) op.s = 2'd2;
      op.a = ($urandom_range(0, 3) == 0) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
      op.b = ($urandom_range(0, 3) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      cycle(op, e);
      n_checks++;
      if (out_valid !== e.v || result !== ACC_W'(e.res) || ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b res=%0d ovf=%b, required v=%b res=%0d ovf=%b",
                 i, out_valid, result, ovf, e.v, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_reset_midstream();
    op_t  op;
    exp_t e;
    op = '{1, 2'd2, 2, 3};
    cycle(op, e);
    cycle(op, e);
    cycle(op, e);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (result !== '0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: result=%0d out_valid=%b ovf=%b, required 0/0/0", result, out_valid, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    op = '{1, 2'd0, 3, 4};
    cycle(op, e);
    n_checks++;
    if (out_valid !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_latency_n1: out_valid=%b result=%0d, required 0/0", out_valid, result);
    end
    op = '{0, 2'd0, 0, 0};
    cycle(op, e);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'sd7 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency_n2: out_valid=%b result=%0d ovf=%b, required 1/7/0", out_valid, result, ovf);
    end
    op = '{1, 2'd2, 5, 5};
    cycle(op, e);
    cycle(op, e);
    n_checks++;
    if (result !== 32'sd25) begin
      n_fail++;
      $display("FAIL reset_acc_cleared: result=%0d, required 25", result);
    end
  endtask

  initial begin
    test_reset();
    test_add_mul();
    test_mac_chain();
    test_bubble();
    test_overflow();
    test_clear_precedence();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
